// File: rtl/handle_translator.sv
// Handle table with allocate/set-base/free/get-base commands and handle-relative address translation.
// Registered response with valid/ready handshake. HANDLE_FAULT_LOG_EN adds a fault counter and last-fault address.
module handle_translator #(
  parameter int ADDR_WIDTH  = 16,
  parameter int HNDL_WIDTH  = 4,
  parameter int NUM_HANDLES = 15
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [2:0]            i_op,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [ADDR_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [2:0]            o_op,
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic [ADDR_WIDTH-1:0] o_data,
  output logic                  o_fault
`ifdef HANDLE_FAULT_LOG_EN
  ,
  output logic [15:0]           o_fault_count,
  output logic [ADDR_WIDTH-1:0] o_last_fault_addr,
  input  logic                  i_fault_clr
`endif
);
  localparam int AW = ADDR_WIDTH;
  localparam int HW = HNDL_WIDTH;
  localparam int OW = AW - HW;
  localparam logic [HW:0] NH = (HW+1)'(NUM_HANDLES);
  localparam logic [2:0] OP_NOP = 3'd0, OP_READ = 3'd1, OP_WRITE = 3'd2;

  typedef struct packed {
    logic [2:0]    op;
    logic [AW-1:0] addr;
    logic [AW-1:0] data;
    logic          fault;
  } resp_t;

  logic [NUM_HANDLES-1:0]         valid_q, valid_d;
  logic [NUM_HANDLES-1:0][AW-1:0] base_q, base_d;
  resp_t                          resp_q, resp_d;
  logic                           o_valid_q, o_valid_d;

  logic          accept, is_cmd, is_rd, is_wr, free_ok;
  logic [HW-1:0] h, t, free_idx;
  logic [OW-1:0] off;

  assign o_ready   = !o_valid_q || i_ready;
  assign accept    = i_valid && o_ready;
  assign h         = i_address[AW-1 -: HW];
  assign off       = i_address[OW-1:0];
  assign t         = i_address[HW-1:0];
  assign is_cmd    = &h;
  assign is_rd     = (i_op == OP_READ);
  assign is_wr     = (i_op == OP_WRITE);

  // Lowest invalid entry wins: scan downward so the last hit is the smallest index.
  always_comb begin
    free_ok  = 1'b0;
    free_idx = '0;
    for (int i = NUM_HANDLES-1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_ok  = 1'b1;
        free_idx = HW'(i);
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    base_d  = base_q;
    resp_d  = '0;
    if (is_rd || is_wr) begin
      if (is_cmd) begin
        if (is_rd && (&t)) begin
          if (free_ok) begin
            valid_d[free_idx] = 1'b1;
            base_d[free_idx]  = '0;
            resp_d.data       = {{(AW-HW){1'b0}}, free_idx};
          end else begin
            resp_d.data  = '1;
            resp_d.fault = 1'b1;
          end
        end else if ({1'b0, t} >= NH) begin
          resp_d.fault = 1'b1;
        end else if (is_rd) begin
          if (valid_q[t]) resp_d.data = base_q[t];
          else            resp_d.fault = 1'b1;
        end else begin
          // Zero data frees the entry; anything else sets its base.
          valid_d[t] = (i_data != '0);
          base_d[t]  = i_data;
        end
      end else begin
        resp_d.fault = 1'b1;
        if ({1'b0, h} < NH) begin
          if (valid_q[h]) begin
            resp_d.op    = i_op;
            resp_d.addr  = base_q[h] + {{HW{1'b0}}, off};
            resp_d.data  = i_data;
            resp_d.fault = 1'b0;
          end
        end
      end
    end
    if (!accept) begin
      valid_d = valid_q;
      base_d  = base_q;
      resp_d  = resp_q;
    end
    o_valid_d = accept ? 1'b1 : (i_ready ? 1'b0 : o_valid_q);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      valid_q   <= '0;
      base_q    <= '0;
      resp_q    <= '0;
      o_valid_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      base_q    <= base_d;
      resp_q    <= resp_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign o_valid   = o_valid_q;
  assign o_op      = resp_q.op;
  assign o_address = resp_q.addr;
  assign o_data    = resp_q.data;
  assign o_fault   = resp_q.fault;

`ifdef HANDLE_FAULT_LOG_EN
  logic [15:0]   fcnt_q, fcnt_d;
  logic [AW-1:0] faddr_q, faddr_d;

  always_comb begin
    fcnt_d  = fcnt_q;
    faddr_d = faddr_q;
    if (i_fault_clr) begin
      fcnt_d  = '0;
      faddr_d = '0;
    end else if (accept && resp_d.fault) begin
      if (!(&fcnt_q)) fcnt_d = fcnt_q + 16'd1;
      faddr_d = i_address;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fcnt_q  <= '0;
      faddr_q <= '0;
    end else begin
      fcnt_q  <= fcnt_d;
      faddr_q <= faddr_d;
    end
  end

  assign o_fault_count     = fcnt_q;
  assign o_last_fault_addr = faddr_q;
`endif
endmodule

// File: tb/tb_handle_translator.sv
// Scoreboard bench for handle_translator: directed scenarios plus random traffic against a table model.
module tb_handle_translator;
  logic        clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_valid = 1'b0, o_ready, o_valid, i_ready = 1'b1, o_fault;
  logic [2:0]  i_op = 3'd0, o_op;
  logic [15:0] i_address = '0, i_data = '0, o_address, o_data;
`ifdef HANDLE_FAULT_LOG_EN
  logic [15:0] o_fault_count, o_last_fault_addr;
  logic        i_fault_clr = 1'b0;
`endif

  handle_translator #(.ADDR_WIDTH(16), .HNDL_WIDTH(4), .NUM_HANDLES(15)) dut (
    .i_clock(clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_address(i_address), .i_data(i_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_op(o_op), .o_address(o_address), .o_data(o_data),
    .o_fault(o_fault)
`ifdef HANDLE_FAULT_LOG_EN
    , .o_fault_count(o_fault_count), .o_last_fault_addr(o_last_fault_addr),
    .i_fault_clr(i_fault_clr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] addr;
    logic [15:0] data;
    logic        fault;
    logic        dchk;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, failures = 0;
  bit          rdy_rand = 1'b1;
  logic        mv[16];
  logic [15:0] mb[16];
  int          fcnt = 0;
  logic [15:0] faddr = '0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) begin mv[k] = 1'b0; mb[k] = '0; end
    fcnt = 0; faddr = '0;
  endtask

  // Reference behaviour: computes the response and applies the table update.
  task automatic model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] d, output exp_t e);
    int h, t, off, k;
    h = int'(a[15:12]); t = int'(a[3:0]); off = int'(a[11:0]);
    e = '{op: 3'd0, addr: 16'd0, data: 16'd0, fault: 1'b0, dchk: 1'b1};
    if (op == 3'd1 || op == 3'd2) begin
      if (h == 15) begin
        if (op == 3'd1 && t == 15) begin
          k = 0;
          while (k < 15 && mv[k]) k++;
          if (k < 15) begin mv[k] = 1'b1; mb[k] = '0; e.data = 16'(k); end
          else begin e.data = 16'hFFFF; e.fault = 1'b1; end
        end else if (t >= 15) begin
          e.fault = 1'b1; e.dchk = 1'b0;
        end else if (op == 3'd1) begin
          if (mv[t]) e.data = mb[t]; else e.fault = 1'b1;
        end else begin
          e.dchk = 1'b0;
          mv[t] = (d != 0);
          mb[t] = (d != 0) ? d : 16'd0;
        end
      end else if (h < 15 && mv[h]) begin
        e.op = op; e.addr = 16'((int'(mb[h]) + off) % 65536); e.data = d;
      end else begin
        e.fault = 1'b1;
      end
    end
    if (e.fault) begin
      if (fcnt < 65535) fcnt++;
      faddr = a;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] d, output int waits);
    exp_t e;
    bit   done = 1'b0;
    waits = 0;
    i_valid = 1'b1; i_op = op; i_address = a; i_data = d;
    while (!done) begin
      #1;
      if (o_ready) begin
        model(op, a, d, e);
        q.push_back(e);
        done = 1'b1;
      end
      @(negedge clk);
      if (!done) begin
        waits++;
        if (waits > 200) begin
          checks++; failures++;
          $display("FAIL accept_timeout: request 0x%04h never accepted", a);
          done = 1'b1;
        end
      end
    end
    i_valid = 1'b0; i_op = 3'd0;
  endtask

  task automatic req(input logic [2:0] op, input logic [15:0] a, input logic [15:0] d);
    int w;
    send(op, a, d, w);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || o_valid) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin
      checks++; failures++;
      $display("FAIL drain_timeout: %0d responses outstanding", q.size());
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rdy_rand) i_ready = ($urandom % 4) != 0;
  end

  // Monitor: a transfer happens at the next posedge when o_valid && i_ready here.
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (i_reset_n && o_valid && i_ready) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_resp: got addr 0x%04h data 0x%04h with empty scoreboard", o_address, o_data);
      end else begin
        e = q.pop_front();
        chk("resp_op", {13'd0, o_op}, {13'd0, e.op});
        chk("resp_addr", o_address, e.addr);
        chk("resp_fault", {15'd0, o_fault}, {15'd0, e.fault});
        if (e.dchk) chk("resp_data", o_data, e.data);
      end
    end
  end

  initial begin
    logic [15:0] snap_a, snap_d;
    logic [2:0]  snap_op;
    int w;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_valid", {15'd0, o_valid}, 16'd0);
    chk("reset_ready", {15'd0, o_ready}, 16'd1);
    chk("reset_data", o_data, 16'd0);
    i_reset_n = 1'b1;
    @(negedge clk);

    // allocation, set-base, translation, free
    req(3'd1, 16'hF00F, 16'h0);
    req(3'd1, 16'hF00F, 16'h0);
    req(3'd2, 16'hF000, 16'h1200);
    req(3'd1, 16'h0034, 16'h0);
    req(3'd2, 16'hF000, 16'h0000);
    req(3'd1, 16'h0034, 16'h0);
    req(3'd1, 16'hF000, 16'h0);
    req(3'd2, 16'hF00F, 16'h5555);
    req(3'd5, 16'h1234, 16'h9999);
    drain();

    // full table from a clean reset
    i_reset_n = 1'b0; model_reset(); #1; i_reset_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 16; k++) req(3'd1, 16'hF00F, 16'h0);
    req(3'd2, 16'hF003, 16'hFFF0);
    req(3'd2, 16'h3020, 16'hABCD);
    req(3'd1, 16'hF003, 16'h0);
    drain();

    // backpressure: response held for five cycles, then drain and accept together
    rdy_rand = 1'b0; i_ready = 1'b0;
    req(3'd2, 16'h3020, 16'h1111);
    #1;
    snap_a = o_address; snap_d = o_data; snap_op = o_op;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", {15'd0, o_valid}, 16'd1);
      chk("bp_ready", {15'd0, o_ready}, 16'd0);
      chk("bp_addr", o_address, snap_a);
      chk("bp_data", o_data, snap_d);
      chk("bp_op", {13'd0, o_op}, {13'd0, snap_op});
      @(negedge clk); #1;
    end
    @(negedge clk);
    i_ready = 1'b1;
    send(3'd1, 16'h3001, 16'h0, w);
    chk("bp_same_cycle_accept", 16'(w), 16'd0);
    rdy_rand = 1'b1;
    drain();

    // reset while a response is pending
    rdy_rand = 1'b0; i_ready = 1'b0;
    req(3'd1, 16'h3020, 16'h0);
    #1;
    chk("pre_reset_valid", {15'd0, o_valid}, 16'd1);
    i_reset_n = 1'b0;
    #1;
    chk("async_reset_valid", {15'd0, o_valid}, 16'd0);
    chk("async_reset_addr", o_address, 16'd0);
    chk("async_reset_ready", {15'd0, o_ready}, 16'd1);
    q.delete(); model_reset();
    @(negedge clk);
    i_reset_n = 1'b1; rdy_rand = 1'b1;
    req(3'd1, 16'h0034, 16'h0);
    drain();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [2:0]  op;
      logic [15:0] a, d;
      int r;
      r  = int'($urandom % 8);
      op = (r < 3) ? 3'd1 : (r < 6) ? 3'd2 : 3'(r);
      if ($urandom % 2) a = {4'hF, 8'($urandom), 4'($urandom)};
      else              a = 16'($urandom);
      d = (($urandom % 4) == 0) ? 16'd0 : 16'($urandom);
      req(op, a, d);
      if (($urandom % 4) == 0) @(negedge clk);
    end
    drain();

`ifdef HANDLE_FAULT_LOG_EN
    i_fault_clr = 1'b1;
    @(negedge clk);
    i_fault_clr = 1'b0;
    fcnt = 0; faddr = '0;
    chk("flog_clear", o_fault_count, 16'd0);
    req(3'd2, 16'hF00F, 16'h1);
    req(3'd2, 16'hF12F, 16'h2);
    req(3'd2, 16'hFABF, 16'h3);
    drain();
    chk("flog_count", o_fault_count, 16'd3);
    chk("flog_count_model", o_fault_count, 16'(fcnt));
    chk("flog_addr", o_last_fault_addr, 16'hFABF);
`endif

    chk("scoreboard_empty", 16'(q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/handle_translator.md
Name: handle_translator

Overview:
- Parametrised, registered successor to the handle-command cell array.
- Holds a table of NUM_HANDLES handle→base entries and services handle commands: allocate, set base, free, read base.
- Translates handle-relative addresses into physical addresses.
- Sits between the core memory port and the memory bus.
- Adds valid/ready handshaking, fault reporting and a 1-cycle output register.

Parameters:
- ADDR_WIDTH, 16, width of address/data buses.
- HNDL_WIDTH, 4, handle field width; handle value all-ones is reserved as the command region.
- NUM_HANDLES, 15, table entries; legal range 1..2^HNDL_WIDTH-1.

Ports:
- i_clock  in  1  single clock, rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  request valid.
- o_ready  out  1  request accepted when i_valid & o_ready.
- i_op  in  3  0=NOP, 1=READ, 2=WRITE; other values are treated as NOP.
- i_address  in  ADDR_WIDTH  request address.
- i_data  in  ADDR_WIDTH  write data / command operand.
- o_valid  out  1  response valid.
- i_ready  in  1  downstream accepts response.
- o_op  out  3  forwarded op; NOP for commands and faults.
- o_address  out  ADDR_WIDTH  translated address; 0 for commands and faults.
- o_data  out  ADDR_WIDTH  forwarded data or command result.
- o_fault  out  1  response carries a fault.

Behaviour:
- Address fields:
  - h = i_address[AW-1:AW-HW]
  - off = i_address[AW-HW-1:0]
  - Command when h is all-ones; the command target is t = i_address[HW-1:0].
- Table: per entry a valid bit and a base register of ADDR_WIDTH bits. On reset all entries are invalid with base 0.
- Handshake:
  - o_ready = !o_valid | i_ready.
  - On accept, the table update and the response register load on the same edge; latency is 1 cycle.
  - o_valid is held with o_op/o_address/o_data/o_fault stable until i_ready. Simultaneous drain and accept is a full-throughput case.
- Table updates commit at the accept edge. The next accepted request (back-to-back) sees the new state; there is no hazard window.
- READ command, t all-ones (ALLOC):
  - Picks the lowest invalid index, sets it valid with base 0, and returns the zero-extended index in o_data.
  - If no entry is free: o_data=all-ones, o_fault=1, no update.
- READ command, t < NUM_HANDLES (GETBASE):
  - Returns o_data=base.
  - If the entry is invalid: o_data=0 and o_fault=1.
- WRITE command, i_data≠0 (SETBASE): base[t]=i_data, valid[t]=1.
- WRITE command, i_data=0 (FREE): valid[t]=0, base[t]=0. Freeing an invalid entry is legal, with no fault.
- Commands with t ≥ NUM_HANDLES, other than ALLOC, give o_fault=1 with no update.
- All commands give o_op=NOP and o_address=0.
- Translation (READ/WRITE, not a command):
  - If h < NUM_HANDLES and the entry is valid: o_op=i_op, o_address=(base+off) mod 2^ADDR_WIDTH (off zero-extended), o_data=i_data, o_fault=0.
  - Otherwise: o_op=NOP, o_address=0, o_data=0, o_fault=1.
- NOP accepted: the response has o_op=NOP and all other outputs 0, with no update.
- Reset:
  - Asserting i_reset_n low at any time, including with a response pending, clears o_valid, o_op, o_address, o_data, o_fault and the table immediately. The pending response is dropped.
  - o_ready is 1 in reset, since o_valid=0.

Optional Feature:
- Macro: HANDLE_FAULT_LOG_EN.
- Defined:
  - Adds o_fault_count (16, saturating at 0xFFFF, incremented on each accepted faulting request).
  - Adds o_last_fault_addr (ADDR_WIDTH, i_address of the most recent faulting request).
  - Adds i_fault_clr (1, synchronous clear of both; clear wins over a same-cycle increment).
  - Both reset to 0.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Defaults, after reset: READ 0xF00F → o_data=0x0000, o_fault=0. A second READ 0xF00F → o_data=0x0001.
- WRITE 0xF000 data 0x1200, then READ 0x0034 back-to-back → o_op=READ, o_address=0x1234, o_fault=0.
- WRITE 0xF000 data 0x0000, then READ 0x0034 → o_op=NOP, o_address=0, o_fault=1. READ 0xF000 → o_data=0, o_fault=1.
- Full table and wrap-around:
  - 15 ALLOCs return 0x0000..0x000E; the 16th → o_data=0xFFFF, o_fault=1.
  - SETBASE handle 3 to 0xFFF0, then WRITE 0x3020 → o_address=0x0010.
- Backpressure: hold i_ready=0 for 5 cycles after a response → o_valid stays 1, outputs stable, o_ready=0. Release → the next request is accepted the same cycle.
- Reset mid-operation: pulse i_reset_n low while o_valid=1 → o_valid=0 asynchronously. After release, READ 0x0034 → fault.
- With HANDLE_FAULT_LOG_EN, 3 faults → o_fault_count=3 and o_last_fault_addr matches the third address.
